// File: rtl/jacobi_pkg.sv
// Shared types and sizing helpers for the Jacobi pivot controller and rotation unit.
package jacobi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_ISSUE,
        ST_WAIT_ROT,
        ST_FINISH
    } jacobi_state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned max_iters);
        return $clog2(max_iters + 1);
    endfunction

    function automatic int unsigned pair_count(input int unsigned n);
        return (n * (n - 1)) / 2;
    endfunction

endpackage

// File: rtl/jacobi_pivot_ctrl_pair_counter.sv
// Walks the strict upper triangle (i<j) in row-major order, one pair per step.
module pair_counter
    import jacobi_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  clear_in,
    input  logic                  step_in,
    output logic [idx_w(N)-1:0]   i_out,
    output logic [idx_w(N)-1:0]   j_out,
    output logic                  last_out
);

    localparam int unsigned IW = idx_w(N);
    localparam logic [IW-1:0] LAST_I = IW'(N - 2);
    localparam logic [IW-1:0] LAST_J = IW'(N - 1);

    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            i_q <= '0;
            j_q <= '0;
        end else if (clear_in) begin
            i_q <= '0;
            j_q <= IW'(1);
        end else if (step_in) begin
            // Wrap to the first column right of the diagonal on the next row.
            if (j_q == LAST_J) begin
                i_q <= i_q + IW'(1);
                j_q <= i_q + IW'(2);
            end else begin
                j_q <= j_q + IW'(1);
            end
        end
    end

    assign i_out    = i_q;
    assign j_out    = j_q;
    assign last_out = (i_q == LAST_I) && (j_q == LAST_J);

endmodule

// File: rtl/jacobi_pivot_ctrl.sv
// Jacobi sweep controller: finds the largest off-diagonal magnitude, issues the
// (p,q) rotation, and repeats until convergence or the iteration cap.
module jacobi_pivot_ctrl
    import jacobi_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned N_STOCKS  = 4,
    parameter int unsigned MAX_ITERS = 32,
    parameter int unsigned THRESH    = 4
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            start_in,
    output logic [idx_w(N_STOCKS)-1:0]      rd_i_out,
    output logic [idx_w(N_STOCKS)-1:0]      rd_j_out,
    input  logic [WIDTH-1:0]                rd_data_in,
    output logic                            rot_valid_out,
    input  logic                            rot_ready_in,
    output logic [idx_w(N_STOCKS)-1:0]      rot_p_out,
    output logic [idx_w(N_STOCKS)-1:0]      rot_q_out,
    input  logic                            rot_done_in,
    output logic                            busy_out,
    output logic                            done_out,
    output logic                            converged_out,
    output logic [cnt_w(MAX_ITERS)-1:0]     iter_count_out
);

    localparam int unsigned IDX_W = idx_w(N_STOCKS);
    localparam int unsigned CNT_W = cnt_w(MAX_ITERS);
    localparam int unsigned MAG_W = WIDTH + 1;
    localparam logic [MAG_W-1:0] THRESH_M = MAG_W'(THRESH);
    localparam logic [CNT_W-1:0] ITER_CAP = CNT_W'(MAX_ITERS);

    jacobi_state_e    state_q;
    logic             scan_addr_q;
    logic             pv_q;
    logic             plast_q;
    logic [IDX_W-1:0] pi_q, pj_q;
    logic [MAG_W-1:0] best_q;
    logic [IDX_W-1:0] bp_q, bq_q;
    logic             rot_valid_q;
    logic [IDX_W-1:0] rot_p_q, rot_q_q;
    logic             busy_q, done_q, conv_q;
    logic [CNT_W-1:0] iter_q;

    logic [MAG_W-1:0] data_ext, mag_c, best_d;
    logic [IDX_W-1:0] bp_d, bq_d;
    logic [CNT_W-1:0] iter_inc;
    logic             take_c, pc_clear_c, pc_step_c, pc_last;

    pair_counter #(.N(N_STOCKS)) u_pair_counter (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .clear_in (pc_clear_c),
        .step_in  (pc_step_c),
        .i_out    (rd_i_out),
        .j_out    (rd_j_out),
        .last_out (pc_last)
    );

    // Magnitude is one bit wider so the most negative value maps exactly.
    always_comb begin
        data_ext   = {rd_data_in[WIDTH-1], rd_data_in};
        mag_c      = data_ext[MAG_W-1] ? (MAG_W'(0) - data_ext) : data_ext;
        take_c     = pv_q && (mag_c > best_q);
        best_d     = take_c ? mag_c : best_q;
        bp_d       = take_c ? pi_q : bp_q;
        bq_d       = take_c ? pj_q : bq_q;
        iter_inc   = iter_q + CNT_W'(1);
        pc_clear_c = ((state_q == ST_IDLE) && start_in) ||
                     ((state_q == ST_WAIT_ROT) && rot_done_in);
        pc_step_c  = (state_q == ST_SCAN) && scan_addr_q && !pc_last;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            scan_addr_q <= 1'b0;
            pv_q        <= 1'b0;
            plast_q     <= 1'b0;
            pi_q        <= '0;
            pj_q        <= '0;
            best_q      <= '0;
            bp_q        <= '0;
            bq_q        <= '0;
            rot_valid_q <= 1'b0;
            rot_p_q     <= '0;
            rot_q_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            conv_q      <= 1'b0;
            iter_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_q     <= ST_SCAN;
                        busy_q      <= 1'b1;
                        conv_q      <= 1'b0;
                        iter_q      <= '0;
                        scan_addr_q <= 1'b1;
                        pv_q        <= 1'b0;
                        best_q      <= '0;
                        bp_q        <= '0;
                        bq_q        <= IDX_W'(1);
                    end
                end
                ST_SCAN: begin
                    // Delay the presented address by one cycle to line up with RAM data.
                    pv_q    <= scan_addr_q;
                    pi_q    <= rd_i_out;
                    pj_q    <= rd_j_out;
                    plast_q <= pc_last;
                    best_q  <= best_d;
                    bp_q    <= bp_d;
                    bq_q    <= bq_d;
                    if (scan_addr_q && pc_last) begin
                        scan_addr_q <= 1'b0;
                    end
                    if (pv_q && plast_q) begin
                        pv_q <= 1'b0;
                        if (best_d <= THRESH_M) begin
                            state_q <= ST_FINISH;
                            conv_q  <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_ISSUE;
                            rot_valid_q <= 1'b1;
                            rot_p_q     <= bp_d;
                            rot_q_q     <= bq_d;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (rot_ready_in) begin
                        state_q     <= ST_WAIT_ROT;
                        rot_valid_q <= 1'b0;
                    end
                end
                ST_WAIT_ROT: begin
                    if (rot_done_in) begin
                        iter_q <= iter_inc;
                        if (iter_inc == ITER_CAP) begin
                            state_q <= ST_FINISH;
                            conv_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q     <= ST_SCAN;
                            scan_addr_q <= 1'b1;
                            pv_q        <= 1'b0;
                            best_q      <= '0;
                            bp_q        <= '0;
                            bq_q        <= IDX_W'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rot_valid_out  = rot_valid_q;
    assign rot_p_out      = rot_p_q;
    assign rot_q_out      = rot_q_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;
    assign converged_out  = conv_q;
    assign iter_count_out = iter_q;

endmodule
